// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port, variable-latency memory interface between the
// instruction-fetch requester (i_*) and the MEM-stage requester (d_*).
// The granted requester's command is forwarded combinationally to the memory
// port and the memory response is routed back to that requester only.
// A response watchdog aborts a grant that waits too long for mem_resp, and a
// saturating counter records fetch stall cycles for performance debug.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_read           : fetch read request (level, held until i_resp)
//   i_address        : fetch byte address
//   i_resp, i_rdata  : fetch completion and read data
//   d_read, d_write  : data read / write request (held until d_resp)
//   d_wmask          : data write byte enables
//   d_address        : data byte address
//   d_wdata          : data write value
//   d_resp, d_rdata  : data completion and read data
//   mem_read, mem_write, mem_wmask, mem_address, mem_wdata : memory command
//   mem_resp, mem_rdata : memory completion and read data
//   timeout_err      : sticky watchdog abort flag
//   i_stall_cnt      : saturating count of cycles with i_read & ~i_resp
//
// TIMEOUT_CYCLES : SERVE cycles without mem_resp before the watchdog aborts
//                  the grant (legal range 2..255).

`timescale 1ns / 1ps

module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,

   // Fetch port
   input  logic        i_read,
   input  logic [15:0] i_address,
   output logic        i_resp,
   output logic [15:0] i_rdata,

   // Data port
   input  logic        d_read,
   input  logic        d_write,
   input  logic [1:0]  d_wmask,
   input  logic [15:0] d_address,
   input  logic [15:0] d_wdata,
   output logic        d_resp,
   output logic [15:0] d_rdata,

   // Memory port
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  mem_wmask,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   input  logic        mem_resp,
   input  logic [15:0] mem_rdata,

   // Debug / status
   output logic        timeout_err,
   output logic [15:0] i_stall_cnt
);

   // Watchdog fires when the counter reaches this value with no mem_resp.
   localparam logic [7:0] WdogLimit = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StServeI = 2'd1,
      StServeD = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  wdog_q, wdog_d;
   logic        timeout_err_q, timeout_err_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic d_req;
   logic serving;
   logic timeout;
   logic done;

   assign d_req   = d_read | d_write;
   assign serving = (state_q != StIdle);
   assign timeout = serving & ~mem_resp & (wdog_q == WdogLimit);
   // A grant ends either by a real memory response or by a watchdog abort.
   assign done    = serving & (mem_resp | timeout);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            // Data first so a stalled MEM stage unblocks the pipeline.
            if (d_req) begin
               state_d = StServeD;
            end else if (i_read) begin
               state_d = StServeI;
            end
         end
         StServeI: begin
            // The just-served port is ignored on completion: strict alternation.
            if (done) begin
               state_d = d_req ? StServeD : StIdle;
            end
         end
         StServeD: begin
            if (done) begin
               state_d = i_read ? StServeI : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Watchdog restarts at 0 on every new grant; it only counts waiting cycles.
   always_comb begin
      wdog_d = 8'd0;
      if (serving && !done) begin
         wdog_d = wdog_q + 8'd1;
      end
   end

   assign timeout_err_d = timeout_err_q | timeout;

   // ---------------------------------------------------------------------
   // Memory command and response routing
   // ---------------------------------------------------------------------
   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_wmask   = 2'b00;
      mem_address = 16'h0000;
      mem_wdata   = 16'h0000;
      i_resp      = 1'b0;
      i_rdata     = 16'h0000;
      d_resp      = 1'b0;
      d_rdata     = 16'h0000;
      case (state_q)
         StServeI: begin
            // Command is withdrawn in the abort cycle.
            mem_read    = ~timeout;
            mem_address = i_address;
            i_resp      = done;
            i_rdata     = timeout ? 16'h0000 : mem_rdata;
         end
         StServeD: begin
            // Read and write together are treated as a write.
            mem_read    = d_read & ~d_write & ~timeout;
            mem_write   = d_write & ~timeout;
            mem_wmask   = d_wmask;
            mem_address = d_address;
            mem_wdata   = d_wdata;
            d_resp      = done;
            d_rdata     = timeout ? 16'h0000 : mem_rdata;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Fetch stall counter (saturating)
   // ---------------------------------------------------------------------
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (i_read && !i_resp && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         wdog_q        <= 8'd0;
         timeout_err_q <= 1'b0;
         stall_cnt_q   <= 16'h0000;
      end else begin
         state_q       <= state_d;
         wdog_q        <= wdog_d;
         timeout_err_q <= timeout_err_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign timeout_err = timeout_err_q;
   assign i_stall_cnt = stall_cnt_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port, variable-latency memory interface between the pipeline's instruction-fetch stage and its MEM stage. The arbiter sits between the pipeline and a single memory port, for example one port of the dual-port memory model. It forwards the granted requester's command and routes the response back to that requester. It also provides a response-timeout watchdog and a saturating fetch-stall counter for performance debug.

## Interface
- `TIMEOUT_CYCLES`, default 64: cycles a grant may wait for `mem_resp` before the watchdog aborts it (legal range 2..255).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_read` in 1: fetch read request, level, held until `i_resp`.
- `i_address` in 16: fetch byte address.
- `i_resp` out 1: fetch request complete this cycle.
- `i_rdata` out 16: fetch read data, valid when `i_resp`.
- `d_read` in 1: data read request, held until `d_resp`.
- `d_write` in 1: data write request, held until `d_resp`.
- `d_wmask` in 2: byte enables for the data write.
- `d_address` in 16: data byte address.
- `d_wdata` in 16: data write value.
- `d_resp` out 1: data request complete this cycle.
- `d_rdata` out 16: data read data, valid when `d_resp`.
- `mem_read`, `mem_write` out 1: command to the memory port.
- `mem_wmask` out 2, `mem_address` out 16, `mem_wdata` out 16: command fields.
- `mem_resp` in 1: memory completion. Legal in the first granted cycle.
- `mem_rdata` in 16: memory read data.
- `timeout_err` out 1: sticky watchdog flag.
- `i_stall_cnt` out 16: saturating count of cycles with `i_read` high and `i_resp` low.

## Operation
- States: IDLE, SERVE_I, SERVE_D. The state register is the only grant record.
- IDLE:
  - d_req (`d_read|d_write`) goes to SERVE_D. Data has priority to unblock the pipeline.
  - Otherwise `i_read` goes to SERVE_I.
  - Otherwise the arbiter stays in IDLE.
- Memory command (combinational from state and the granted port):
  - SERVE_I: `mem_read`=1, `mem_write`=0, `mem_address`=`i_address`.
  - SERVE_D: `mem_read`=`d_read & ~d_write`, `mem_write`=`d_write`. Read and write both high is treated as a write. Address, mask and wdata come from the d port.
  - IDLE: all `mem_*` outputs are 0.
- Response routing:
  - In SERVE_x, `mem_resp` gives `x_resp`=1 that same cycle, with `x_rdata`=`mem_rdata`.
  - The ungranted port's resp is 0.
  - `i_rdata`/`d_rdata` equal `mem_rdata` when granted, else 0.
- Completion transition: on `mem_resp` in SERVE_x:
  - Go to SERVE_other if the other port requests that cycle, else IDLE.
  - The just-served port's still-high request is ignored that cycle, which guarantees alternation and no starvation.
- Watchdog:
  - An 8-bit counter clears on entry to any SERVE state and increments each SERVE cycle without `mem_resp`.
  - When it equals `TIMEOUT_CYCLES-1` without `mem_resp`, the arbiter:
    - forces `x_resp`=1 with `x_rdata`=16'h0000;
    - deasserts `mem_read`/`mem_write` that cycle;
    - sets `timeout_err`;
    - takes the same next-state decision as a normal completion.
  - `timeout_err` clears only on reset.
- Stall counter: increments each cycle with `i_read & ~i_resp`. It saturates at 16'hFFFF and does not wrap.
- Request withdrawal before resp is a protocol violation and is not checked. The command simply follows the inputs combinationally.

## Timing
- Reset (async assert, sync release): state IDLE, watchdog 0, `timeout_err` 0, `i_stall_cnt` 0. All `mem_*`, `*_resp` and `*_rdata` outputs are 0.
- Minimum latency: request sampled in IDLE at edge N; command issued in cycle N+1; resp in cycle N+1 if memory answers immediately. Requester sees 2 cycles total.
- Back-to-back alternation: the second port's command appears in the cycle after the first port's resp, with no IDLE bubble.
- Same port repeated with no competitor: resp, then IDLE for 1 cycle, then SERVE again. One bubble per access.
- Simultaneous requests in IDLE: D first, then I immediately after.
- Reset mid-SERVE: the grant is dropped immediately with no resp. Requesters re-arbitrate from IDLE.

## Test plan
- Lone fetch, memory resp in first cycle: `i_read`=1, `i_address`=16'h3000 → `mem_read`=1 and `i_resp`=1 in cycle 2, `i_rdata`=`mem_rdata`, `i_stall_cnt`=1.
- Simultaneous `i_read` and `d_write` (`d_address`=16'h4000, `d_wdata`=16'hBEEF, mask 2'b11), memory latency 3 → write is granted first; `d_resp` in cycle 4; fetch command in cycle 5 with no bubble; `i_resp` in cycle 7.
- Continuous `d_read` with `i_read` held high → grants strictly alternate D, I, D, I; neither port waits more than one other access.
- `mem_resp` held 0, `TIMEOUT_CYCLES`=8 → `d_resp`=1 with `d_rdata`=0 in the 8th SERVE cycle, `timeout_err`=1, and it stays set until `rst_n` pulses.
- `d_read` and `d_write` both 1 → `mem_write`=1, `mem_read`=0.
- `rst_n` dropped mid-SERVE_D → all outputs 0 asynchronously. After release, a held request is re-granted two cycles later. `i_stall_cnt` is forced near saturation with `i_read` held high: it sticks at 16'hFFFF.
